// File: rtl/aurora_multilane_pattern_gen.sv
// Multi-lane Aurora 64b/66b Tx test-pattern source: FIXED/COUNT/LANE_COUNT/PRBS31 payloads,
// per-lane mask and burst/gap framing, all lanes advancing in lock-step with the gearboxes.
module aurora_multilane_pattern_gen #(
    parameter int unsigned         NUM_LANES = 8,
    parameter int unsigned         DATA_W    = 64,
    parameter int unsigned         CNT_W     = 32,
    parameter logic [DATA_W-1:0]   IDLE_WORD = 64'h7800_0000_0000_0000
) (
    input  logic                          clk40,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [DATA_W-1:0]             fixed_data,
    input  logic [NUM_LANES-1:0]          lane_mask,
    input  logic [15:0]                   burst_len,
    input  logic [7:0]                    idle_len,
    input  logic [NUM_LANES-1:0]          gearbox_rdy,
    input  logic [NUM_LANES-1:0]          data_next,
    output logic [NUM_LANES*DATA_W-1:0]   data_out,
    output logic [2*NUM_LANES-1:0]        sync_out,
    output logic [CNT_W-1:0]              frame_count,
    output logic                          busy
);

    localparam logic [1:0] SyncData = 2'b01;
    localparam logic [1:0] SyncCtrl = 2'b10;

    typedef enum logic [1:0] {StIdle, StData, StGap} state_e;

    state_e                       state_q, state_d;
    logic [15:0]                  burst_cnt_q, burst_cnt_d, burst_len_q, burst_len_d;
    logic [7:0]                   gap_cnt_q, gap_cnt_d, idle_len_q, idle_len_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d, frame_q, frame_d;
    logic [NUM_LANES*DATA_W-1:0]  data_q, data_d;
    logic [2*NUM_LANES-1:0]       sync_q, sync_d;
    logic [30:0]                  prbs_q [NUM_LANES];
    logic [30:0]                  prbs_d [NUM_LANES];
    logic [30:0]                  prbs_nxt [NUM_LANES];
    logic [DATA_W-1:0]            prbs_word [NUM_LANES];
    logic [DATA_W-1:0]            cnt_ext;
    logic                         adv, emit_data;
    logic [15:0]                  burst_eff, burst_nxt;
    logic [7:0]                   gap_nxt;

    assign adv     = (&gearbox_rdy) & (&data_next);
    assign cnt_ext = DATA_W'(cnt_q);

    // 64 LFSR steps per block, first generated bit lands in the payload MSB
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            prbs_nxt[k]  = prbs_q[k];
            prbs_word[k] = '0;
            for (int i = DATA_W - 1; i >= 0; i--) begin
                prbs_word[k][i] = prbs_nxt[k][30] ^ prbs_nxt[k][27];
                prbs_nxt[k]     = {prbs_nxt[k][29:0], prbs_word[k][i]};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        burst_len_d = burst_len_q;
        gap_cnt_d   = gap_cnt_q;
        idle_len_d  = idle_len_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        data_d      = data_q;
        sync_d      = sync_q;
        prbs_d      = prbs_q;
        emit_data   = 1'b0;
        burst_eff   = burst_len_q;
        burst_nxt   = burst_cnt_q + 16'd1;
        gap_nxt     = gap_cnt_q + 8'd1;

        if (!en) begin
            state_d     = StIdle;
            burst_cnt_d = '0;
            gap_cnt_d   = '0;
            cnt_d       = '0;
            data_d      = '0;
            sync_d      = '0;
            for (int k = 0; k < NUM_LANES; k++) prbs_d[k] = 31'(k + 1);
        end else if (adv) begin
            unique case (state_q)
                StIdle: begin
                    emit_data = 1'b1;
                    burst_eff = burst_len;
                    burst_nxt = 16'd1;
                    frame_d   = CNT_W'(1);
                end
                StData: begin
                    emit_data = 1'b1;
                    if (frame_q != '1) frame_d = frame_q + CNT_W'(1);
                end
                StGap: begin
                    data_d = {NUM_LANES{IDLE_WORD}};
                    sync_d = {NUM_LANES{SyncCtrl}};
                    if (gap_nxt == idle_len_q) begin
                        state_d     = StData;
                        gap_cnt_d   = '0;
                        burst_cnt_d = '0;
                        burst_len_d = burst_len;
                    end else begin
                        gap_cnt_d = gap_nxt;
                    end
                end
                default: ;
            endcase

            if (emit_data) begin
                cnt_d  = cnt_q + CNT_W'(1);
                prbs_d = prbs_nxt;
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (lane_mask[k]) begin
                        sync_d[2*k +: 2] = SyncData;
                        case (mode)
                            2'd0:    data_d[k*DATA_W +: DATA_W] = fixed_data;
                            2'd1:    data_d[k*DATA_W +: DATA_W] = cnt_ext;
                            2'd2:    data_d[k*DATA_W +: DATA_W] = {8'(k), cnt_ext[DATA_W-9:0]};
                            default: data_d[k*DATA_W +: DATA_W] = prbs_word[k];
                        endcase
                    end else begin
                        sync_d[2*k +: 2]            = SyncCtrl;
                        data_d[k*DATA_W +: DATA_W]  = IDLE_WORD;
                    end
                end
                // burst length is only re-sampled where one burst ends and the next begins
                burst_len_d = burst_eff;
                if (burst_eff != 16'd0 && burst_nxt == burst_eff) begin
                    burst_cnt_d = '0;
                    if (idle_len != 8'd0) begin
                        state_d    = StGap;
                        idle_len_d = idle_len;
                        gap_cnt_d  = '0;
                    end else begin
                        state_d     = StData;
                        burst_len_d = burst_len;
                    end
                end else begin
                    burst_cnt_d = burst_nxt;
                    state_d     = StData;
                end
            end
        end
    end

    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            burst_cnt_q <= '0;
            burst_len_q <= '0;
            gap_cnt_q   <= '0;
            idle_len_q  <= '0;
            cnt_q       <= '0;
            frame_q     <= '0;
            data_q      <= '0;
            sync_q      <= '0;
            for (int k = 0; k < NUM_LANES; k++) prbs_q[k] <= 31'(k + 1);
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            burst_len_q <= burst_len_d;
            gap_cnt_q   <= gap_cnt_d;
            idle_len_q  <= idle_len_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            data_q      <= data_d;
            sync_q      <= sync_d;
            prbs_q      <= prbs_d;
        end
    end

    assign data_out    = data_q;
    assign sync_out    = sync_q;
    assign frame_count = frame_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: doc/aurora_multilane_pattern_gen.md
Name: aurora_multilane_pattern_gen

Overview:
Parametrised multi-lane Tx test-pattern source feeding the per-lane Aurora Tx gearboxes (64b payload plus 2b sync header per lane).
Adds four pattern modes, a per-lane enable mask, and burst/idle framing with control blocks.
Exposes a frame counter for ILA/VIO monitoring.
Sits in the clk40 domain between VIO control and the lane array.

Parameters:
NUM_LANES, 8, number of Tx lanes driven
DATA_W, 64, payload width per lane; fixed at 64 for Aurora 64b/66b
CNT_W, 32, width of frame counter and pattern counter
IDLE_WORD, 64'h7800_0000_0000_0000, payload sent with control sync during gaps and on masked lanes

Ports:
clk40  in  1  pattern clock
rst_n  in  1  asynchronous active-low reset
en  in  1  generator enable
mode  in  2  0=FIXED, 1=COUNT, 2=LANE_COUNT, 3=PRBS31
fixed_data  in  DATA_W  payload for FIXED mode
lane_mask  in  NUM_LANES  1=lane carries pattern, 0=lane sends IDLE_WORD
burst_len  in  16  data blocks per burst; 0=continuous
idle_len  in  8  control blocks per gap; 0=no gap
gearbox_rdy  in  NUM_LANES  per-lane Tx gearbox ready
data_next  in  NUM_LANES  per-lane gearbox accepts next block
data_out  out  NUM_LANES*DATA_W  lane k payload at [k*DATA_W +: DATA_W]
sync_out  out  2*NUM_LANES  lane k sync header at [2k +: 2]
frame_count  out  CNT_W  data blocks issued since reset/enable
busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous on rst_n low. While in reset: data_out=0, sync_out=0, frame_count=0, busy=0, state=IDLE, pattern counter=0, lane k PRBS register=k+1.
- Advance strobe: adv = (&gearbox_rdy) & (&data_next). All lanes advance together. Outputs are registered and change only on the clk40 edge where adv=1, so latency is 1 cycle from adv.
- en=0 (synchronous, takes priority over adv):
  - state goes to IDLE, data_out=0, sync_out=0, busy=0.
  - Counters and PRBS registers are reseeded to their reset values.
  - frame_count holds its value.
- State machine:
  - IDLE: on en=1 and adv, go to DATA and emit the first data block; frame_count is cleared to 1.
  - DATA: each adv emits one data block and increments burst_cnt. When burst_len!=0 and burst_cnt reaches burst_len: go to GAP if idle_len!=0, otherwise restart DATA with burst_cnt=0.
  - GAP: each adv emits one control block and increments gap_cnt. When gap_cnt reaches idle_len, go to DATA; burst_cnt and gap_cnt are cleared.
- Data block, unmasked lane k: sync=2'b01, payload by mode:
  - FIXED: fixed_data.
  - COUNT: pattern counter zero-extended to DATA_W; same value on all lanes.
  - LANE_COUNT: {k[7:0], counter[DATA_W-9:0]}.
  - PRBS31: next 64 bits of x^31+x^28+1. Each lane has its own register; the register advances 64 steps per data block, MSB first.
- Pattern counter increments by 1 per data block and wraps modulo 2^CNT_W. The counter and PRBS registers do not advance in GAP.
- Control block: sync=2'b10, payload=IDLE_WORD on all lanes.
- Masked lanes (lane_mask[k]=0): always IDLE_WORD with sync=2'b10 outside IDLE. Their PRBS register still advances, so unmasking mid-run is phase-consistent.
- frame_count increments per data block and saturates at all-ones; it does not wrap.
- mode, fixed_data and lane_mask are sampled on every adv; changes take effect on the next emitted block.
- burst_len and idle_len are sampled only on the DATA/GAP boundary. A burst_len write mid-burst applies to the next burst.
- adv=0 holds all outputs and state unchanged. A single lane deasserting gearbox_rdy stalls all lanes.
- sync_out is never 2'b00 or 2'b11 while busy=1.

Test Plan:
1. Reset mid-stream: assert rst_n=0 in DATA mode COUNT -> data_out=0, sync_out=0, frame_count=0, busy=0 asynchronously. Release with en=1 -> first block count 0, sync 2'b01.
2. FIXED continuous: mode=0, fixed_data=64'hC0CA_C01A_CAFE_0000, burst_len=0, adv every cycle for 100 cycles -> every unmasked lane carries that word with sync 2'b01; frame_count=100.
3. Burst/gap: mode=1, burst_len=4, idle_len=2 -> sequence repeats 0,1,2,3,IDLE,IDLE,4,5,6,7,IDLE,IDLE. Control blocks carry sync 2'b10.
4. Stall: mode=2, drop gearbox_rdy[3] for 5 cycles -> all lanes hold their block. Lane 5 shows top byte 8'h05 with a contiguous counter on resume.
5. Mask and PRBS: mode=3, lane_mask=8'b1010_1010 -> even lanes carry IDLE_WORD/2'b10. Odd lane k matches a reference PRBS31 model seeded k+1. Unmasking lane 2 after 10 blocks -> lane 2 matches its model at step 10.
6. Wrap: CNT_W=8, mode=1, 300 blocks -> payload wraps 255 to 0; frame_count saturates at 8'hFF.
